ofs_plat_shim_ccip_mmio_rd_timeout: RTL and testbench

Sits on the MMIO branch directly downstream of the MMIO/host-memory split, between the FIU-side MMIO channel and the AFU's MMIO responder. Forwards MMIO read requests to the AFU unchanged and tracks each one in order. If the AFU does not answer within a bounded time, the block synthesizes an all-ones read response so the host never hangs. Stale or unmatched AFU responses are dropped.

---
 rtl/ofs_plat_mmio_rd_timeout_pkg.sv | 32 +++
 rtl/ofs_plat_mmio_rd_tracker_fifo.sv | 65 ++++++
 rtl/ofs_plat_shim_ccip_mmio_rd_timeout.sv | 144 ++++++++++++++
 tb/tb_ofs_plat_shim_ccip_mmio_rd_timeout.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofs_plat_mmio_rd_timeout_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ofs_plat_mmio_rd_timeout_pkg
// Purpose  : Shared types and constants for the MMIO read-timeout shim.
// Revision : 1.0 - initial release
// ============================================================================
package ofs_plat_mmio_rd_timeout_pkg;

  typedef logic [8:0]  t_mmio_tid;
  typedef logic [15:0] t_mmio_addr;
  typedef logic [63:0] t_mmio_data;

  // Timestamp storage is sized for the largest supported timeout (32768).
  // The shim only compares the low $clog2(TIMEOUT_CYCLES)+1 bits.
  typedef logic [15:0] t_mmio_ts;

  localparam t_mmio_data MMIO_RD_TIMEOUT_DATA = '1;

  typedef struct packed {
    t_mmio_tid tid;
    t_mmio_ts  start_ts;
  } t_tracker_entry;

  localparam int TRACKER_ENTRY_W = $bits(t_tracker_entry);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ofs_plat_mmio_rd_tracker_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ofs_plat_mmio_rd_tracker_fifo
// Purpose  : In-order register FIFO of outstanding MMIO reads. Head is
//            combinational; push and pop may occur in the same cycle, and a
//            push into a full FIFO succeeds when a pop frees the slot.
// Revision : 1.0 - initial release
// ============================================================================
module ofs_plat_mmio_rd_tracker_fifo
  import ofs_plat_mmio_rd_timeout_pkg::*;
#(
  parameter int DEPTH = 64
)(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [TRACKER_ENTRY_W-1:0] push_data,
  input  logic                       pop,
  output logic [TRACKER_ENTRY_W-1:0] head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [TRACKER_ENTRY_W-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0]         r_wr_ptr;
  logic [c_PTR_W-1:0]         r_rd_ptr;
  logic [c_CNT_W-1:0]         r_count;
  logic                       w_push_ok;
  logic                       w_pop_ok;

  assign full      = (r_count == c_CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  // Entry storage; flushing is done through the pointers, so no reset here.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ofs_plat_shim_ccip_mmio_rd_timeout.sv
`default_nettype none
// ============================================================================
// Module   : ofs_plat_shim_ccip_mmio_rd_timeout
// Purpose  : Forwards MMIO reads to the AFU, tracks them in order and emits
//            an all-ones response for any read the AFU leaves unanswered for
//            TIMEOUT_CYCLES. Late or unmatched AFU responses are dropped.
// Options  : OFS_PLAT_MMIO_RD_TIMEOUT_STATS_EN adds statistics outputs.
// Revision : 1.0 - initial release
// ============================================================================
module ofs_plat_shim_ccip_mmio_rd_timeout
  import ofs_plat_mmio_rd_timeout_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int DEPTH          = 64
)(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rx_mmio_rd_valid,
  input  logic [8:0]             rx_mmio_tid,
  input  logic [15:0]            rx_mmio_addr,
  output logic                   afu_mmio_rd_valid,
  output logic [8:0]             afu_mmio_tid,
  output logic [15:0]            afu_mmio_addr,
  input  logic                   afu_rsp_valid,
  input  logic [8:0]             afu_rsp_tid,
  input  logic [63:0]            afu_rsp_data,
  output logic                   fiu_rsp_valid,
  output logic [8:0]             fiu_rsp_tid,
  output logic [63:0]            fiu_rsp_data,
`ifdef OFS_PLAT_MMIO_RD_TIMEOUT_STATS_EN
  output logic [31:0]            stat_timeouts,
  output logic [31:0]            stat_dropped,
  output logic [$clog2(DEPTH):0] stat_max_outstanding,
`endif
  output logic                   overflow
);

  localparam int                c_TS_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int                c_CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [c_TS_W-1:0] c_TIMEOUT = c_TS_W'(TIMEOUT_CYCLES);

  logic [c_TS_W-1:0]          r_ts;
  logic [TRACKER_ENTRY_W-1:0] w_head;
  t_tracker_entry             w_head_entry;
  t_tracker_entry             w_push_entry;
  logic                       w_full;
  logic                       w_empty;
  logic [c_CNT_W-1:0]         w_count;
  logic [c_TS_W-1:0]          w_age;
  logic                       w_match;
  logic                       w_expired;
  logic                       w_pop;
  logic                       w_unused;

  assign w_head_entry = t_tracker_entry'(w_head);
  // Modulo subtraction keeps the age correct across counter wrap.
  assign w_age     = r_ts - w_head_entry.start_ts[c_TS_W-1:0];
  assign w_match   = afu_rsp_valid && !w_empty && (afu_rsp_tid == w_head_entry.tid);
  // A matching AFU response in the expiry cycle takes priority.
  assign w_expired = !w_empty && (w_age >= c_TIMEOUT) && !w_match;
  assign w_pop     = w_match || w_expired;
  assign w_unused  = ^{w_head_entry.start_ts, w_count};

  // New tracker entry: request TID stamped with the current time.
  always_comb begin
    w_push_entry          = '0;
    w_push_entry.tid      = rx_mmio_tid;
    w_push_entry.start_ts = t_mmio_ts'(r_ts);
  end

  ofs_plat_mmio_rd_tracker_fifo #(
    .DEPTH (DEPTH)
  ) u_tracker (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rx_mmio_rd_valid),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  // Free-running timestamp.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ts <= '0;
    else          r_ts <= r_ts + c_TS_W'(1);
  end

  // Request pass-through toward the AFU, one cycle of latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      afu_mmio_rd_valid <= 1'b0;
      afu_mmio_tid      <= '0;
      afu_mmio_addr     <= '0;
    end else begin
      afu_mmio_rd_valid <= rx_mmio_rd_valid;
      afu_mmio_tid      <= rx_mmio_tid;
      afu_mmio_addr     <= rx_mmio_addr;
    end
  end

  // Response toward the FIU: real AFU data on a match, all-ones on expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fiu_rsp_valid <= 1'b0;
      fiu_rsp_tid   <= '0;
      fiu_rsp_data  <= '0;
    end else begin
      fiu_rsp_valid <= w_pop;
      if (w_pop) begin
        fiu_rsp_tid  <= w_head_entry.tid;
        fiu_rsp_data <= w_match ? afu_rsp_data : MMIO_RD_TIMEOUT_DATA;
      end
    end
  end

  // Sticky flag: a request was forwarded but could not be tracked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overflow <= 1'b0;
    else if (rx_mmio_rd_valid && w_full && !w_pop) overflow <= 1'b1;
  end

`ifdef OFS_PLAT_MMIO_RD_TIMEOUT_STATS_EN
  logic w_drop;
  assign w_drop = afu_rsp_valid && !w_match;

  // Saturating event counters and occupancy high-water mark.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_timeouts        <= '0;
      stat_dropped         <= '0;
      stat_max_outstanding <= '0;
    end else begin
      if (w_expired) stat_timeouts <= sat_inc32(stat_timeouts);
      if (w_drop)    stat_dropped  <= sat_inc32(stat_dropped);
      if (w_count > stat_max_outstanding) stat_max_outstanding <= w_count;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ofs_plat_shim_ccip_mmio_rd_timeout.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofs_plat_shim_ccip_mmio_rd_timeout
// Purpose  : Directed self-checking bench for the MMIO read-timeout shim
//            (TIMEOUT_CYCLES=16, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofs_plat_shim_ccip_mmio_rd_timeout;

  localparam int           T    = 16;
  localparam int           D    = 4;
  localparam logic [63:0]  ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_mmio_rd_valid;
  logic [8:0]  rx_mmio_tid;
  logic [15:0] rx_mmio_addr;
  logic        afu_mmio_rd_valid;
  logic [8:0]  afu_mmio_tid;
  logic [15:0] afu_mmio_addr;
  logic        afu_rsp_valid;
  logic [8:0]  afu_rsp_tid;
  logic [63:0] afu_rsp_data;
  logic        fiu_rsp_valid;
  logic [8:0]  fiu_rsp_tid;
  logic [63:0] fiu_rsp_data;
  logic        overflow;
`ifdef OFS_PLAT_MMIO_RD_TIMEOUT_STATS_EN
  logic [31:0] stat_timeouts;
  logic [31:0] stat_dropped;
  logic [2:0]  stat_max_outstanding;
`endif

  int checks   = 0;
  int failures = 0;

  // Bench model of the DUT timestamp (5 bits for T=16).
  logic [4:0] tb_ts;

  ofs_plat_shim_ccip_mmio_rd_timeout #(
    .TIMEOUT_CYCLES (T),
    .DEPTH          (D)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .rx_mmio_rd_valid     (rx_mmio_rd_valid),
    .rx_mmio_tid          (rx_mmio_tid),
    .rx_mmio_addr         (rx_mmio_addr),
    .afu_mmio_rd_valid    (afu_mmio_rd_valid),
    .afu_mmio_tid         (afu_mmio_tid),
    .afu_mmio_addr        (afu_mmio_addr),
    .afu_rsp_valid        (afu_rsp_valid),
    .afu_rsp_tid          (afu_rsp_tid),
    .afu_rsp_data         (afu_rsp_data),
    .fiu_rsp_valid        (fiu_rsp_valid),
    .fiu_rsp_tid          (fiu_rsp_tid),
    .fiu_rsp_data         (fiu_rsp_data),
`ifdef OFS_PLAT_MMIO_RD_TIMEOUT_STATS_EN
    .stat_timeouts        (stat_timeouts),
    .stat_dropped         (stat_dropped),
    .stat_max_outstanding (stat_max_outstanding),
`endif
    .overflow             (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_ts <= 5'd0;
    else          tb_ts <= tb_ts + 5'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request now and count cycles until the first FIU response.
  task automatic issue_and_wait(input logic [8:0] tid, input int max, output int n);
    int i;
    rx_mmio_rd_valid = 1'b1;
    rx_mmio_tid      = tid;
    rx_mmio_addr     = 16'h0040;
    n = -1;
    i = 0;
    while (n < 0 && i < max) begin
      step();
      i++;
      if (i == 1) rx_mmio_rd_valid = 1'b0;
      if (fiu_rsp_valid) n = i;
    end
    rx_mmio_rd_valid = 1'b0;
  endtask

  initial begin
    int n;
    int nrsp;
    int guard;
    logic [8:0]  rtid [8];
    int          rcyc [8];
    logic [63:0] rdat [8];

    reset_n          = 1'b0;
    rx_mmio_rd_valid = 1'b0;
    rx_mmio_tid      = '0;
    rx_mmio_addr     = '0;
    afu_rsp_valid    = 1'b0;
    afu_rsp_tid      = '0;
    afu_rsp_data     = '0;

    // ---------------- reset state ----------------
    step(); step();
    chk("rst_afu_valid", 64'(afu_mmio_rd_valid), 64'd0);
    chk("rst_afu_tid",   64'(afu_mmio_tid),      64'd0);
    chk("rst_afu_addr",  64'(afu_mmio_addr),     64'd0);
    chk("rst_fiu_valid", 64'(fiu_rsp_valid),     64'd0);
    chk("rst_fiu_tid",   64'(fiu_rsp_tid),       64'd0);
    chk("rst_fiu_data",  fiu_rsp_data,           64'd0);
    chk("rst_overflow",  64'(overflow),          64'd0);
`ifdef OFS_PLAT_MMIO_RD_TIMEOUT_STATS_EN
    chk("rst_stat_to",   64'(stat_timeouts),     64'd0);
    chk("rst_stat_drop", 64'(stat_dropped),      64'd0);
`endif
    reset_n = 1'b1;
    step(); step();

    // ---------------- normal read ----------------
    rx_mmio_rd_valid = 1'b1; rx_mmio_tid = 9'h005; rx_mmio_addr = 16'h0010;
    step();                                   // cycle 1
    chk("t1_afu_valid", 64'(afu_mmio_rd_valid), 64'd1);
    chk("t1_afu_tid",   64'(afu_mmio_tid),      64'h5);
    chk("t1_afu_addr",  64'(afu_mmio_addr),     64'h10);
    rx_mmio_rd_valid = 1'b0;
    step();                                   // cycle 2
    chk("t1_afu_valid_drop", 64'(afu_mmio_rd_valid), 64'd0);
    step();                                   // cycle 3
    afu_rsp_valid = 1'b1; afu_rsp_tid = 9'h005; afu_rsp_data = 64'h1234;
    step();                                   // cycle 4
    chk("t1_fiu_valid", 64'(fiu_rsp_valid), 64'd1);
    chk("t1_fiu_tid",   64'(fiu_rsp_tid),   64'h5);
    chk("t1_fiu_data",  fiu_rsp_data,       64'h1234);
    afu_rsp_valid = 1'b0;
    step();
    chk("t1_fiu_single", 64'(fiu_rsp_valid), 64'd0);

    // ---------------- timeout then late response ----------------
    issue_and_wait(9'h007, 40, n);
    chk("t2_latency",  64'(n),           64'd17);
    chk("t2_fiu_tid",  64'(fiu_rsp_tid), 64'h7);
    chk("t2_fiu_data", fiu_rsp_data,     ONES);
    step();                                   // cycle 18
    chk("t2_fiu_pulse", 64'(fiu_rsp_valid), 64'd0);
    step(); step();                           // cycle 20
    afu_rsp_valid = 1'b1; afu_rsp_tid = 9'h007; afu_rsp_data = 64'hDEAD;
    step();
    chk("t2_late_dropped", 64'(fiu_rsp_valid), 64'd0);
    afu_rsp_valid = 1'b0;
    step();
    chk("t2_late_quiet", 64'(fiu_rsp_valid), 64'd0);
`ifdef OFS_PLAT_MMIO_RD_TIMEOUT_STATS_EN
    chk("t2_stat_dropped",  64'(stat_dropped),  64'd1);
    chk("t2_stat_timeouts", 64'(stat_timeouts), 64'd1);
`endif

    // ---------------- tie: AFU answers in the expiry cycle ----------------
    rx_mmio_rd_valid = 1'b1; rx_mmio_tid = 9'h009;
    step();                                   // cycle 1
    rx_mmio_rd_valid = 1'b0;
    for (int i = 2; i <= 16; i++) step();     // cycle 16
    chk("t3_no_early", 64'(fiu_rsp_valid), 64'd0);
    afu_rsp_valid = 1'b1; afu_rsp_tid = 9'h009; afu_rsp_data = 64'hABCD;
    step();                                   // cycle 17
    chk("t3_fiu_valid", 64'(fiu_rsp_valid), 64'd1);
    chk("t3_fiu_tid",   64'(fiu_rsp_tid),   64'h9);
    chk("t3_fiu_data",  fiu_rsp_data,       64'hABCD);
    afu_rsp_valid = 1'b0;
    step();
    chk("t3_single_rsp", 64'(fiu_rsp_valid), 64'd0);

    // ---------------- full tracker (DEPTH=4) ----------------
    for (int i = 0; i < 5; i++) begin
      rx_mmio_rd_valid = 1'b1; rx_mmio_tid = 9'(9'h010 + i);
      step();
      if (i == 3) chk("t4_no_overflow_yet", 64'(overflow), 64'd0);
    end
    rx_mmio_rd_valid = 1'b0;                  // now at cycle 5
    chk("t4_fifth_forwarded", 64'(afu_mmio_tid),      64'h14);
    chk("t4_fifth_valid",     64'(afu_mmio_rd_valid), 64'd1);
    chk("t4_overflow",        64'(overflow),          64'd1);
    nrsp = 0;
    for (int c = 6; c <= 30; c++) begin
      step();
      if (fiu_rsp_valid) begin
        if (nrsp < 8) begin
          rtid[nrsp] = fiu_rsp_tid;
          rcyc[nrsp] = c;
          rdat[nrsp] = fiu_rsp_data;
        end
        nrsp++;
      end
    end
    chk("t4_rsp_count", 64'(nrsp), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t4_rsp_tid",  64'(rtid[i]), 64'(16 + i));
      chk("t4_rsp_cyc",  64'(rcyc[i]), 64'(17 + i));
      chk("t4_rsp_data", rdat[i],      ONES);
    end
    chk("t4_overflow_sticky", 64'(overflow), 64'd1);

    // ---------------- timestamp wrap ----------------
    guard = 0;
    while (tb_ts != 5'd29 && guard < 64) begin
      step();
      guard++;
    end
    issue_and_wait(9'h01A, 40, n);
    chk("t5_wrap_latency", 64'(n),           64'd17);
    chk("t5_wrap_tid",     64'(fiu_rsp_tid), 64'h1A);
    chk("t5_wrap_data",    fiu_rsp_data,     ONES);
    step();

    // ---------------- reset mid-operation ----------------
    for (int i = 0; i < 3; i++) begin
      rx_mmio_rd_valid = 1'b1; rx_mmio_tid = 9'(9'h021 + i); rx_mmio_addr = 16'h0100;
      step();
    end
    rx_mmio_rd_valid = 1'b0;
    reset_n = 1'b0;
    step(); step();
    chk("t6_rst_afu_valid", 64'(afu_mmio_rd_valid), 64'd0);
    chk("t6_rst_afu_tid",   64'(afu_mmio_tid),      64'd0);
    chk("t6_rst_afu_addr",  64'(afu_mmio_addr),     64'd0);
    chk("t6_rst_fiu_valid", 64'(fiu_rsp_valid),     64'd0);
    chk("t6_rst_fiu_data",  fiu_rsp_data,           64'd0);
    chk("t6_rst_overflow",  64'(overflow),          64'd0);
`ifdef OFS_PLAT_MMIO_RD_TIMEOUT_STATS_EN
    chk("t6_rst_stat_to",   64'(stat_timeouts),     64'd0);
    chk("t6_rst_stat_max",  64'(stat_max_outstanding), 64'd0);
`endif
    reset_n = 1'b1;
    nrsp = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (fiu_rsp_valid) nrsp++;
    end
    chk("t6_no_stale_rsp", 64'(nrsp), 64'd0);
    issue_and_wait(9'h030, 40, n);
    chk("t6_new_latency", 64'(n),           64'd17);
    chk("t6_new_tid",     64'(fiu_rsp_tid), 64'h30);
    chk("t6_new_data",    fiu_rsp_data,     ONES);
    chk("t6_overflow",    64'(overflow),    64'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
